// File: rtl/program_loader.sv
// rtl/program_loader.sv - byte-stream boot loader that fills program memory and releases the core
// Optional checksum byte and check enabled by PROGRAM_LOADER_CSUM_EN.
module program_loader #(
    parameter int WORDS = 32,
    localparam int AW = (WORDS > 1) ? $clog2(WORDS) : 1
) (
    input  logic          clk,
    input  logic          Reset,
    input  logic [7:0]    InData,
    input  logic          InValid,
    output logic          InReady,
    output logic          PM_WE,
    output logic [AW-1:0] PM_Addr,
    output logic [12:0]   PM_Data,
    output logic          CoreRun,
    output logic          Busy,
    output logic          Error
);

    localparam logic [8:0] MAX_N = 9'(WORDS);

    typedef enum logic [2:0] {
        S_IDLE, S_COUNT, S_HI, S_LO, S_CSUM, S_RUN, S_ERR
    } state_t;

`ifdef PROGRAM_LOADER_CSUM_EN
    localparam state_t AFTER_LAST = S_CSUM;
`else
    localparam state_t AFTER_LAST = S_RUN;
`endif

    state_t        state_q, state_d;
    logic [AW-1:0] addr_q, last_q;
    logic [4:0]    hi_q;
    logic          in_ready_q, pm_we_q, core_run_q, busy_q, error_q;
    logic [AW-1:0] pm_addr_q;
    logic [12:0]   pm_data_q;
    logic          accept;
`ifdef PROGRAM_LOADER_CSUM_EN
    logic [7:0]    csum_q;
`endif

    assign accept = InValid & in_ready_q;

    always_comb begin
        state_d = state_q;
        if (accept) begin
            case (state_q)
                S_IDLE, S_ERR: if (InData == 8'hA5) state_d = S_COUNT;
                S_COUNT: state_d = (InData == 8'h00 || {1'b0, InData} > MAX_N) ? S_ERR : S_HI;
                S_HI:    state_d = (InData[7:5] != 3'b000) ? S_ERR : S_LO;
                S_LO:    state_d = (addr_q != last_q) ? S_HI : AFTER_LAST;
`ifdef PROGRAM_LOADER_CSUM_EN
                S_CSUM:  state_d = (InData == csum_q) ? S_RUN : S_ERR;
`endif
                default: state_d = state_q;
            endcase
        end
    end

    // Status outputs are registered from the next state so they line up with state_q.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            last_q     <= '0;
            hi_q       <= '0;
            in_ready_q <= 1'b1;
            pm_we_q    <= 1'b0;
            pm_addr_q  <= '0;
            pm_data_q  <= '0;
            core_run_q <= 1'b0;
            busy_q     <= 1'b0;
            error_q    <= 1'b0;
`ifdef PROGRAM_LOADER_CSUM_EN
            csum_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != S_RUN);
            core_run_q <= (state_d == S_RUN);
            error_q    <= (state_d == S_ERR);
            busy_q     <= state_d inside {S_COUNT, S_HI, S_LO, S_CSUM};
            pm_we_q    <= 1'b0;
            if (accept) begin
                case (state_q)
                    S_COUNT: begin
                        addr_q <= '0;
                        last_q <= AW'(InData - 8'd1);
`ifdef PROGRAM_LOADER_CSUM_EN
                        csum_q <= '0;
`endif
                    end
                    S_HI: begin
                        hi_q <= InData[4:0];
`ifdef PROGRAM_LOADER_CSUM_EN
                        csum_q <= csum_q ^ InData;
`endif
                    end
                    S_LO: begin
                        pm_we_q   <= 1'b1;
                        pm_addr_q <= addr_q;
                        pm_data_q <= {hi_q, InData};
`ifdef PROGRAM_LOADER_CSUM_EN
                        csum_q    <= csum_q ^ InData;
`endif
                        if (addr_q != last_q) addr_q <= addr_q + AW'(1);
                    end
                    default: ;
                endcase
            end
        end
    end

    assign InReady = in_ready_q;
    assign PM_WE   = pm_we_q;
    assign PM_Addr = pm_addr_q;
    assign PM_Data = pm_data_q;
    assign CoreRun = core_run_q;
    assign Busy    = busy_q;
    assign Error   = error_q;

endmodule

// File: tb/tb_program_loader.sv
// tb/tb_program_loader.sv - randomized scoreboard bench for program_loader
// Honours PROGRAM_LOADER_CSUM_EN the same way as the design.
module tb_program_loader;

    localparam int ST_IDLE = 0, ST_BUSY = 1, ST_RUN = 2, ST_ERR = 3;

    typedef struct packed {
        logic [4:0]  addr;
        logic [12:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        Reset = 1'b1;
    logic [7:0]  InData = 8'h00;
    logic        InValid = 1'b0;
    logic        InReady, PM_WE, CoreRun, Busy, Error;
    logic [4:0]  PM_Addr;
    logic [12:0] PM_Data;

    program_loader #(.WORDS(32)) dut (
        .clk(clk), .Reset(Reset), .InData(InData), .InValid(InValid),
        .InReady(InReady), .PM_WE(PM_WE), .PM_Addr(PM_Addr), .PM_Data(PM_Data),
        .CoreRun(CoreRun), .Busy(Busy), .Error(Error)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    wr_t  exp_q[$];
    bit   we_due = 1'b0;

    logic [7:0] hist[$];
    logic [7:0] chunk[$];
    wr_t        m_wr[$];
    bit         m_lo[$];
    int         m_st;
    int         n_pushed = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: parse the whole byte history since reset as frames.
    task automatic model_run();
        int i = 0;
        int n;
        logic [7:0] hi, lo, x, c;
        bit bad;
        m_wr.delete();
        m_lo.delete();
        foreach (hist[k]) m_lo.push_back(1'b0);
        m_st = ST_IDLE;
        while (i < hist.size()) begin
            if (hist[i] != 8'hA5) begin i++; continue; end
            i++;
            m_st = ST_BUSY;
            if (i >= hist.size()) return;
            n = int'(hist[i]);
            i++;
            if (n == 0 || n > 32) begin m_st = ST_ERR; continue; end
            x = 8'h00;
            bad = 1'b0;
            for (int w = 0; w < n; w++) begin
                if (i >= hist.size()) return;
                hi = hist[i];
                i++;
                if (hi[7:5] != 3'b000) begin bad = 1'b1; break; end
                if (i >= hist.size()) return;
                lo = hist[i];
                m_lo[i] = 1'b1;
                i++;
                m_wr.push_back('{addr: 5'(w), data: {hi[4:0], lo}});
                x = x ^ hi ^ lo;
            end
            if (bad) begin m_st = ST_ERR; continue; end
`ifdef PROGRAM_LOADER_CSUM_EN
            if (i >= hist.size()) return;
            c = hist[i];
            i++;
            if (c != x) begin m_st = ST_ERR; continue; end
`else
            c = x;
`endif
            m_st = ST_RUN;
            return;
        end
    endtask

    always @(negedge clk) begin
        wr_t e;
        if (!Reset) begin
            if (PM_WE || we_due) chk("we_timing", 32'(PM_WE), 32'(we_due));
            if (PM_WE) begin
                if (exp_q.size() == 0) chk("unexpected_write", 32'(PM_Addr), 32'hFFFF_FFFF);
                else begin
                    e = exp_q.pop_front();
                    chk("pm_addr", 32'(PM_Addr), 32'(e.addr));
                    chk("pm_data", 32'(PM_Data), 32'(e.data));
                end
            end
            we_due = 1'b0;
        end
    end

    task automatic check_reset_outputs();
        chk("rst_in_ready", 32'(InReady), 32'd1);
        chk("rst_core_run", 32'(CoreRun), 32'd0);
        chk("rst_pm_we",    32'(PM_WE),   32'd0);
        chk("rst_error",    32'(Error),   32'd0);
        chk("rst_busy",     32'(Busy),    32'd0);
        chk("rst_pm_addr",  32'(PM_Addr), 32'd0);
        chk("rst_pm_data",  32'(PM_Data), 32'd0);
    endtask

    task automatic clear_model();
        hist.delete();
        exp_q.delete();
        n_pushed = 0;
        we_due = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        Reset = 1'b1;
        InValid = 1'b0;
        #1;
        check_reset_outputs();
        clear_model();
        @(negedge clk);
        Reset = 1'b0;
    endtask

    task automatic check_status();
        chk("core_run", 32'(CoreRun), 32'(m_st == ST_RUN));
        chk("error",    32'(Error),   32'(m_st == ST_ERR));
        chk("busy",     32'(Busy),    32'(m_st == ST_BUSY));
        chk("in_ready", 32'(InReady), 32'(m_st != ST_RUN));
    endtask

    task automatic send_byte(input logic [7:0] b, input bit lo, input int gap);
        repeat (gap) begin
            @(negedge clk);
            InValid = 1'b0;
            InData = 8'($urandom);
        end
        @(negedge clk);
        InData = b;
        InValid = 1'b1;
        chk("ready_before_byte", 32'(InReady), 32'd1);
        chk("run_before_byte", 32'(CoreRun), 32'd0);
        @(posedge clk);
        #1;
        InValid = 1'b0;
        we_due = lo;
    endtask

    task automatic send_chunk(input int gapmax, input bit tail);
        int base = hist.size();
        foreach (chunk[j]) hist.push_back(chunk[j]);
        model_run();
        while (n_pushed < m_wr.size()) begin
            exp_q.push_back(m_wr[n_pushed]);
            n_pushed++;
        end
        foreach (chunk[j]) send_byte(chunk[j], m_lo[base + j], $urandom_range(0, gapmax));
        if (tail) begin
            @(negedge clk);
            #1;
            check_status();
            chk("writes_drained", 32'(exp_q.size()), 32'd0);
        end
    endtask

    task automatic load_chunk(input logic [63:0] v, input int nb);
        chunk.delete();
        for (int i = 0; i < nb; i++) chunk.push_back(v[8*(nb-1-i) +: 8]);
    endtask

    task automatic build_frame(input int n, input int corrupt);
        logic [7:0] hi, lo, x, g;
        int bad_w;
        chunk.delete();
        repeat ($urandom_range(0, 2)) begin
            g = 8'($urandom);
            chunk.push_back(g == 8'hA5 ? 8'h5A : g);
        end
        chunk.push_back(8'hA5);
        if (corrupt == 1) begin
            chunk.push_back($urandom_range(0, 1) ? 8'h00 : 8'($urandom_range(33, 255)));
            return;
        end
        chunk.push_back(8'(n));
        bad_w = $urandom_range(0, n - 1);
        x = 8'h00;
        for (int w = 0; w < n; w++) begin
            hi = 8'($urandom_range(0, 31));
            if (corrupt == 2 && w == bad_w) begin
                hi[7:5] = 3'($urandom_range(1, 7));
                chunk.push_back(hi);
                return;
            end
            lo = 8'($urandom);
            chunk.push_back(hi);
            chunk.push_back(lo);
            x = x ^ hi ^ lo;
        end
`ifdef PROGRAM_LOADER_CSUM_EN
        chunk.push_back(corrupt == 3 ? (x ^ 8'(1 << $urandom_range(0, 7))) : x);
`endif
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();

`ifdef PROGRAM_LOADER_CSUM_EN
        load_chunk(64'hA5_02_01_23_1F_00_3D, 7);
`else
        load_chunk(64'hA5_02_01_23_1F_00, 6);
`endif
        send_chunk(0, 1);

        do_reset();
`ifdef PROGRAM_LOADER_CSUM_EN
        load_chunk(64'hA5_02_01_23_1F_00_3C, 7);
        send_chunk(0, 1);
        load_chunk(64'hA5_01_00_07_07, 5);
`else
        load_chunk(64'hA5_01_20, 3);
        send_chunk(0, 1);
        load_chunk(64'hA5_01_00_07, 4);
`endif
        send_chunk(0, 1);

        do_reset();
        load_chunk(64'hA5_00, 2);
        send_chunk(0, 1);
        load_chunk(64'hA5_21, 2);
        send_chunk(0, 1);
        load_chunk(64'hA5_01_20, 3);
        send_chunk(0, 1);
`ifdef PROGRAM_LOADER_CSUM_EN
        load_chunk(64'h12_34_A5_01_00_07_07, 7);
`else
        load_chunk(64'h12_34_A5_01_00_07, 6);
`endif
        send_chunk(1, 1);

        do_reset();
        build_frame(32, 0);
        send_chunk(3, 1);

        // Abort a frame while the third word's write pulse is still high.
        do_reset();
        chunk.delete();
        chunk.push_back(8'hA5);
        chunk.push_back(8'h08);
        for (int w = 0; w < 3; w++) begin
            chunk.push_back(8'($urandom_range(0, 31)));
            chunk.push_back(8'($urandom));
        end
        send_chunk(1, 0);
        #1;
        Reset = 1'b1;
        #1;
        check_reset_outputs();
        chk("aborted_write_pending", 32'(exp_q.size()), 32'd1);
        clear_model();
        repeat (2) @(negedge clk);
        Reset = 1'b0;
        build_frame($urandom_range(1, 32), 0);
        send_chunk(2, 1);

        for (int t = 0; t < 20; t++) begin
            do_reset();
            build_frame($urandom_range(1, 32), $urandom_range(0, 3));
            send_chunk(2, 1);
            if (m_st != ST_RUN) begin
                build_frame($urandom_range(1, 32), 0);
                send_chunk(2, 1);
            end
        end

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/program_loader.md
# program_loader

Boot-time program loader upstream of the processor core. Receives a byte stream over a valid/ready handshake, assembles 13-bit instruction words, and writes them into the 32-entry writable program memory. Once a complete, checksum-verified image is stored, it releases the core by asserting `CoreRun`, which gates the core's reset. The core's program counter stays parked at address 0 until the load completes.

## Interface
- `WORDS`, default 32: program memory depth. Address width is 5 bits at the default.
- `clk`, in, 1: system clock; all state updates on the rising edge.
- `Reset`, in, 1: asynchronous, active-high reset.
- `InData`, in, 8: incoming stream byte.
- `InValid`, in, 1: `InData` is valid.
- `InReady`, out, 1: loader accepts a byte this cycle. A byte transfers when `InValid & InReady`.
- `PM_WE`, out, 1: program memory write enable, a one-cycle pulse.
- `PM_Addr`, out, 5: program memory write address.
- `PM_Data`, out, 13: program memory write data.
- `CoreRun`, out, 1: high once the image is loaded. The core's `nReset` is driven from `CoreRun`.
- `Busy`, out, 1: high from the accepted header until the `RUN` or `ERR` state is reached.
- `Error`, out, 1: high while in the `ERR` state.

## Operation
- **Frame format:**
  - Header `0xA5`.
  - Count byte N (1..32).
  - N word pairs, each a HI byte then a LO byte. HI[4:0] carries instruction bits [12:8]; LO carries bits [7:0].
  - Checksum byte: XOR of all 2N data bytes.
- **States:** `IDLE`, `COUNT`, `HI`, `LO`, `CSUM`, `RUN`, `ERR`.
- **`IDLE`:** accepts any byte. `0xA5` → `COUNT`; any other byte is discarded and the state stays `IDLE`.
- **`COUNT`:**
  - N = 0 or N > `WORDS` → `ERR`.
  - Otherwise store N, clear the address counter and checksum → `HI`.
- **`HI`:**
  - If HI[7:5] ≠ 0 → `ERR`.
  - Otherwise latch HI[4:0], XOR the byte into the checksum → `LO`.
- **`LO`:**
  - Register `{HI[4:0], LO}` into `PM_Data` and the address counter into `PM_Addr`; pulse `PM_WE` next cycle; XOR LO into the checksum.
  - If this is the last word (address = N−1) → `CSUM`.
  - Otherwise increment the address → `HI`.
- **`CSUM`:** byte equal to the running XOR → `RUN`; mismatch → `ERR`.
- **`RUN`:** `CoreRun` = 1 and `InReady` = 0. The state is held until `Reset`; there is no reload without reset.
- **`ERR`:** `InReady` = 1 and `CoreRun` = 0. Bytes other than `0xA5` are discarded. `0xA5` → `COUNT`, which clears `Error` and starts a fresh frame.
- The address counter never wraps. N ≤ `WORDS` guarantees the last write is to address N−1 ≤ 31.
- Memory contents written before an error are not cleared. `CoreRun` stays low, so they are never executed.

## Timing
- **Reset values:**
  - State `IDLE`.
  - `InReady` = 1 (it is 1 in every state except `RUN`, and 0 only in `RUN`).
  - `PM_WE` = 0, `PM_Addr` = 0, `PM_Data` = 0.
  - `CoreRun` = 0, `Busy` = 0, `Error` = 0.
- `InReady` is a function of the registered state only; it never depends combinationally on `InValid`.
- One byte is accepted per cycle maximum, so back-to-back streaming needs no stalls.
- **Write latency:** `PM_WE` is high exactly one cycle, in the cycle after the LO byte is accepted. `PM_Addr`/`PM_Data` are stable during that cycle.
- `CoreRun` rises in the cycle after the valid checksum byte is accepted (after the final LO byte when checksum is disabled).
- Cycles with `InValid` low leave all state unchanged and keep `PM_WE` = 0.
- **Reset mid-frame:** all outputs return to reset values immediately, without waiting for a clock edge. A `PM_WE` pulse in flight is aborted.

## Configuration
- `PROGRAM_LOADER_CSUM_EN`:
  - **Defined:** the `CSUM` state and the checksum byte exist as described.
  - **Undefined:** no checksum byte is sent and the checksum logic is removed. `LO` on the last word goes directly to `RUN`, and `CoreRun` rises the cycle after the last LO byte is accepted.

## Test plan
- **Reset:** assert `Reset` → `InReady` = 1, `CoreRun` = 0, `PM_WE` = 0, `Error` = 0, `Busy` = 0.
- **Two-word load:** stream `A5 02 01 23 1F 00 3D` (checksum enabled) → writes 0x0123 to addr 0 and 0x1F00 to addr 1, each as a single `PM_WE` cycle; `CoreRun` = 1 one cycle after `3D`; `InReady` = 0 thereafter.
- **Bad checksum, then recovery:** same stream with checksum `3C` → `Error` = 1, `CoreRun` = 0. Then `A5 01 00 07 07` → `Error` = 0; 0x0007 is written to addr 0; `CoreRun` = 1.
- **Invalid count and bad HI byte:**
  - `A5 00` → `ERR`; `A5 21` → `ERR`.
  - `A5 01 20 ..` (HI[7:5] ≠ 0) → `ERR` with no `PM_WE`.
  - Garbage `12 34` before `A5` is ignored and the frame loads normally.
- **Full image with gaps:** N = 32 with `InValid` gaps inserted → 32 writes with addresses 0..31 in order; the last write is to addr 31; state unchanged during gaps.
- **Reset mid-load:** assert `Reset` after the 3rd word → outputs return to reset values immediately; a following complete frame loads correctly. Rerun the two-word load without `PROGRAM_LOADER_CSUM_EN` and without the `3D` byte → `CoreRun` rises one cycle after byte `00`.
